// File: rtl/dashboard_bcd_formatter.sv
// ============================================================================
// dashboard_bcd_formatter
//
// Purpose:
//   Samples the simulated engine rev and vehicle speed at a fixed display
//   refresh rate. Each sample is converted to packed BCD with a sequential
//   double-dabble engine that handles one binary bit per clock. The result is
//   presented to the tachometer / speedometer digit drivers with a one-cycle
//   valid strobe.
//
// Parameters:
//   CLK_FREQ_HZ  input clock frequency
//   UPDATE_HZ    sample/convert rate (tick period = CLK_FREQ_HZ/UPDATE_HZ)
//   SHIFT_RPM    shift-light full-on threshold (shift-light build only)
//
// Ports:
//   clk            in   1   clock, single domain
//   rst            in   1   synchronous active-high reset
//   engine_rev     in  14   engine rpm, unsigned binary
//   vehicle_speed  in   9   vehicle speed, unsigned binary
//   rev_bcd        out 20   five BCD digits of captured rev ([19:16] = 10k)
//   speed_bcd      out 12   three BCD digits of captured speed ([11:8] = 100s)
//   bcd_valid      out  1   one-cycle pulse when rev_bcd/speed_bcd update
//   busy           out  1   high while a conversion is in progress
//   shift_light    out  4   thermometer shift indicator
//
// Configuration macro:
//   DASH_SHIFT_LIGHT_EN  when defined, builds the shift-light threshold and
//                        blink logic; otherwise shift_light is tied to 0000.
// ============================================================================
module dashboard_bcd_formatter #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int UPDATE_HZ   = 10,
   parameter int SHIFT_RPM   = 6500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] engine_rev,
   input  logic [8:0]  vehicle_speed,
   output logic [19:0] rev_bcd,
   output logic [11:0] speed_bcd,
   output logic        bcd_valid,
   output logic        busy,
   output logic [3:0]  shift_light
);

   localparam int TICK_PERIOD = CLK_FREQ_HZ / UPDATE_HZ;
   localparam int TIMER_W     = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TICK_PERIOD - 1);

   // A conversion takes 16 cycles from capture back to IDLE, so a shorter
   // refresh period could never be honoured.
   if (TICK_PERIOD < 16) begin : gBadTickPeriod
      $error("dashboard_bcd_formatter: CLK_FREQ_HZ/UPDATE_HZ must be >= 16");
   end

   if (SHIFT_RPM < 0) begin : gBadShiftRpm
      $error("dashboard_bcd_formatter: SHIFT_RPM must be non-negative");
   end

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   // Double-dabble correction: every nibble of 5 or more gets +3 so that the
   // following left shift carries correctly into the next decimal digit.
   function automatic logic [19:0] addThree20(input logic [19:0] v);
      logic [19:0] r;
      r = v;
      for (int i = 0; i < 5; i++) begin
         if (v[i*4 +: 4] >= 4'd5) begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   function automatic logic [11:0] addThree12(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      for (int i = 0; i < 3; i++) begin
         if (v[i*4 +: 4] >= 4'd5) begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               tick;

   state_t      state_q, state_d;
   logic [3:0]  bitCnt_q, bitCnt_d;
   logic [13:0] revBin_q, revBin_d;
   logic [8:0]  speedBin_q, speedBin_d;
   logic [19:0] revScr_q, revScr_d;
   logic [11:0] speedScr_q, speedScr_d;
   logic [19:0] revBcd_q, revBcd_d;
   logic [11:0] speedBcd_q, speedBcd_d;
   logic        valid_q, valid_d;

   logic [19:0] revAdj;
   logic [11:0] speedAdj;

   // Free-running refresh timer; the terminal count is the sample tick and
   // the timer never pauses, so ticks seen while busy are simply lost.
   always_comb begin
      tick    = (timer_q == TIMER_LAST);
      timer_d = tick ? '0 : timer_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   assign revAdj   = addThree20(revScr_q);
   assign speedAdj = addThree12(speedScr_q);

   // Next-state logic for the converter FSM. IDLE waits for a tick and
   // captures both inputs; SHIFT runs 14 iterations (speed only uses the
   // first 9); DONE transfers the scratch digits to the output registers
   // together with the valid strobe.
   always_comb begin
      state_d    = state_q;
      bitCnt_d   = bitCnt_q;
      revBin_d   = revBin_q;
      speedBin_d = speedBin_q;
      revScr_d   = revScr_q;
      speedScr_d = speedScr_q;
      revBcd_d   = revBcd_q;
      speedBcd_d = speedBcd_q;
      valid_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (tick) begin
               revBin_d   = engine_rev;
               speedBin_d = vehicle_speed;
               revScr_d   = '0;
               speedScr_d = '0;
               bitCnt_d   = '0;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            revScr_d = (revAdj << 1) | {19'd0, revBin_q[13]};
            revBin_d = revBin_q << 1;
            if (bitCnt_q < 4'd9) begin
               speedScr_d = (speedAdj << 1) | {11'd0, speedBin_q[8]};
               speedBin_d = speedBin_q << 1;
            end
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd13) begin
               state_d = DONE;
            end
         end
         DONE: begin
            revBcd_d   = revScr_q;
            speedBcd_d = speedScr_q;
            valid_d    = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Converter state and output registers. Reset abandons any conversion in
   // flight and clears the presented digits.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         bitCnt_q   <= '0;
         revBin_q   <= '0;
         speedBin_q <= '0;
         revScr_q   <= '0;
         speedScr_q <= '0;
         revBcd_q   <= '0;
         speedBcd_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bitCnt_q   <= bitCnt_d;
         revBin_q   <= revBin_d;
         speedBin_q <= speedBin_d;
         revScr_q   <= revScr_d;
         speedScr_q <= speedScr_d;
         revBcd_q   <= revBcd_d;
         speedBcd_q <= speedBcd_d;
         valid_q    <= valid_d;
      end
   end

   assign rev_bcd   = revBcd_q;
   assign speed_bcd = speedBcd_q;
   assign bcd_valid = valid_q;
   assign busy      = (state_q != IDLE);

`ifdef DASH_SHIFT_LIGHT_EN
   localparam int BLINK_PERIOD = (CLK_FREQ_HZ / 8 > 1) ? CLK_FREQ_HZ / 8 : 2;
   localparam int BLINK_W      = $clog2(BLINK_PERIOD);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD - 1);
   localparam int LVL1_RPM     = SHIFT_RPM - 1500;
   localparam int LVL2_RPM     = SHIFT_RPM - 1000;
   localparam int LVL3_RPM     = SHIFT_RPM - 500;

   logic [13:0]        revCap_q, revCap_d;
   logic [3:0]         shiftLight_q, shiftLight_d;
   logic               blinking_q, blinking_d;
   logic [BLINK_W-1:0] blinkCnt_q, blinkCnt_d;
   int                 revCapInt;
   logic [3:0]         level;

   // The binary shift register is consumed by the conversion, so keep an
   // untouched copy of the captured rev for the threshold compare in DONE.
   always_comb begin
      revCap_d = revCap_q;
      if (state_q == IDLE && tick) begin
         revCap_d = engine_rev;
      end
   end

   // Thermometer level for the non-blinking range of the captured rev.
   always_comb begin
      revCapInt = int'(revCap_q);
      level     = 4'b0000;
      if (revCapInt >= LVL3_RPM) begin
         level = 4'b0111;
      end else if (revCapInt >= LVL2_RPM) begin
         level = 4'b0011;
      end else if (revCapInt >= LVL1_RPM) begin
         level = 4'b0001;
      end
   end

   // Shift-light update. While blinking, the phase counter toggles the
   // lamps between 1111 and 0000 every BLINK_PERIOD cycles. A new result in
   // DONE either keeps an ongoing blink running undisturbed, starts a fresh
   // blink in the all-on phase, or drops back to a steady level.
   always_comb begin
      shiftLight_d = shiftLight_q;
      blinking_d   = blinking_q;
      blinkCnt_d   = blinkCnt_q;

      if (blinking_q) begin
         if (blinkCnt_q == BLINK_LAST) begin
            blinkCnt_d   = '0;
            shiftLight_d = ~shiftLight_q;
         end else begin
            blinkCnt_d = blinkCnt_q + 1'b1;
         end
      end

      if (state_q == DONE) begin
         if (revCapInt >= SHIFT_RPM) begin
            if (!blinking_q) begin
               blinking_d   = 1'b1;
               blinkCnt_d   = '0;
               shiftLight_d = 4'b1111;
            end
         end else begin
            blinking_d   = 1'b0;
            blinkCnt_d   = '0;
            shiftLight_d = level;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         revCap_q     <= '0;
         shiftLight_q <= '0;
         blinking_q   <= 1'b0;
         blinkCnt_q   <= '0;
      end else begin
         revCap_q     <= revCap_d;
         shiftLight_q <= shiftLight_d;
         blinking_q   <= blinking_d;
         blinkCnt_q   <= blinkCnt_d;
      end
   end

   assign shift_light = shiftLight_q;
`else
   assign shift_light = 4'b0000;
`endif

endmodule

// File: tb/tb_dashboard_bcd_formatter.sv
// ============================================================================
// tb_dashboard_bcd_formatter
//
// Self-checking bench for dashboard_bcd_formatter with CLK_FREQ_HZ=1000,
// UPDATE_HZ=10 (100-cycle refresh) and SHIFT_RPM=6500. Expected digits come
// from decimal arithmetic on the applied values; the shift-light model works
// from the threshold rules and blink timing. Honours DASH_SHIFT_LIGHT_EN.
// ============================================================================
module tb_dashboard_bcd_formatter;

   localparam int CLK_HZ    = 1000;
   localparam int UPD_HZ    = 10;
   localparam int PERIOD    = CLK_HZ / UPD_HZ;
   localparam int SHIFT_RPM = 6500;
   localparam int BLINK     = CLK_HZ / 8;

   logic        clk;
   logic        rst;
   logic [13:0] engineRev;
   logic [8:0]  vehicleSpeed;
   logic [19:0] revBcd;
   logic [11:0] speedBcd;
   logic        bcdValid;
   logic        busy;
   logic [3:0]  shiftLight;

   int total;
   int bad;
   int cyc;
   int pulses;
   bit blinkOn;
   int blinkStart;

   dashboard_bcd_formatter #(
      .CLK_FREQ_HZ(CLK_HZ),
      .UPDATE_HZ  (UPD_HZ),
      .SHIFT_RPM  (SHIFT_RPM)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .engine_rev   (engineRev),
      .vehicle_speed(vehicleSpeed),
      .rev_bcd      (revBcd),
      .speed_bcd    (speedBcd),
      .bcd_valid    (bcdValid),
      .busy         (busy),
      .shift_light  (shiftLight)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter since reset release: the edge where reset is first seen
   // low makes cyc=1, so capture edges are multiples of PERIOD.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // Count valid pulses, observed away from the active edge.
   always @(negedge clk) begin
      if (bcdValid === 1'b1) pulses <= pulses + 1;
   end

   function automatic logic [19:0] toBcd5(input int v);
      return {4'(v / 10000 % 10), 4'(v / 1000 % 10), 4'(v / 100 % 10),
              4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic logic [11:0] toBcd3(input int v);
      return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   // Shift-light expectation at the result edge c for captured rev r.
   // Tracks the blink start time across results.
   function automatic logic [3:0] lightModel(input int r, input int c);
`ifdef DASH_SHIFT_LIGHT_EN
      if (r >= SHIFT_RPM) begin
         if (!blinkOn) begin
            blinkOn    = 1'b1;
            blinkStart = c;
         end
         return (((c - blinkStart) / BLINK) % 2 == 0) ? 4'b1111 : 4'b0000;
      end
      blinkOn = 1'b0;
      if (r >= SHIFT_RPM - 500)  return 4'b0111;
      if (r >= SHIFT_RPM - 1000) return 4'b0011;
      if (r >= SHIFT_RPM - 1500) return 4'b0001;
      return 4'b0000;
`else
      blinkOn = (r >= SHIFT_RPM) && (c >= 0);
      return 4'b0000;
`endif
   endfunction

   // Blink phase at an arbitrary cycle while the blink is running.
   function automatic logic [3:0] blinkPhase(input int c);
`ifdef DASH_SHIFT_LIGHT_EN
      return (((c - blinkStart) / BLINK) % 2 == 0) ? 4'b1111 : 4'b0000;
`else
      return (c < 0) ? 4'b1111 : 4'b0000;
`endif
   endfunction

   // Advance to the negedge where cyc equals target, with a bounded wait.
   task automatic waitCyc(input int target);
      int guard;
      guard = 0;
      while (cyc != target && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != target) begin
         total++;
         bad++;
         $display("[TB] FAIL waitCyc: reached cyc=%0d required %0d", cyc, target);
      end
   endtask

   function automatic int nextCapture();
      return (cyc / PERIOD + 1) * PERIOD;
   endfunction

   task automatic applyStimulus(input int r, input int s);
      engineRev    = 14'(r);
      vehicleSpeed = 9'(s);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(2000, 0);
      repeat (5) @(negedge clk);
      total++; if (revBcd !== 20'h0)   begin bad++; $display("[TB] FAIL reset_rev: got %h want 00000", revBcd); end
      total++; if (speedBcd !== 12'h0) begin bad++; $display("[TB] FAIL reset_speed: got %h want 000", speedBcd); end
      total++; if (bcdValid !== 1'b0)  begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", bcdValid); end
      total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      total++; if (shiftLight !== 4'h0) begin bad++; $display("[TB] FAIL reset_light: got %b want 0000", shiftLight); end
      blinkOn = 1'b0;
      pulses  = 0;
      rst     = 1'b0;
   endtask

   task automatic test_first_valid();
      logic [3:0] expL;
      waitCyc(114);
      total++; if (bcdValid !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL first_pre: valid=%b busy=%b want 0/1", bcdValid, busy); end
      waitCyc(115);
      expL = lightModel(2000, 115);
      total++; if (bcdValid !== 1'b1) begin bad++; $display("[TB] FAIL first_valid: valid=%b want 1 at cycle 115", bcdValid); end
      total++; if (revBcd !== 20'h02000 || speedBcd !== 12'h000) begin bad++; $display("[TB] FAIL first_data: got %h/%h want 02000/000", revBcd, speedBcd); end
      total++; if (shiftLight !== expL) begin bad++; $display("[TB] FAIL first_light: got %b want %b", shiftLight, expL); end
      waitCyc(116);
      total++; if (bcdValid !== 1'b0 || pulses !== 1) begin bad++; $display("[TB] FAIL first_pulse: valid=%b pulses=%0d want 0/1", bcdValid, pulses); end
      waitCyc(200);
      total++; if (revBcd !== 20'h02000 || bcdValid !== 1'b0) begin bad++; $display("[TB] FAIL hold: got %h valid=%b want 02000/0", revBcd, bcdValid); end
      waitCyc(215);
      total++; if (bcdValid !== 1'b1 || pulses !== 1) begin bad++; $display("[TB] FAIL period: valid=%b pulses=%0d want 1/1", bcdValid, pulses); end
      void'(lightModel(2000, 215));
   endtask

   task automatic test_full_range();
      int busyCnt;
      logic [3:0] expL;
      waitCyc(220);
      applyStimulus(16383, 511);
      waitCyc(299);
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy: got %b want 0", busy); end
      busyCnt = 0;
      for (int c = 300; c < 315; c++) begin
         waitCyc(c);
         if (busy === 1'b1) busyCnt++;
      end
      waitCyc(315);
      expL = lightModel(16383, 315);
      total++; if (busyCnt !== 15 || busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_len: got %0d cycles busy_now=%b want 15/0", busyCnt, busy); end
      total++; if (bcdValid !== 1'b1 || revBcd !== 20'h16383 || speedBcd !== 12'h511) begin bad++; $display("[TB] FAIL full_range: valid=%b got %h/%h want 16383/511", bcdValid, revBcd, speedBcd); end
      total++; if (shiftLight !== expL) begin bad++; $display("[TB] FAIL full_light: got %b want %b", shiftLight, expL); end
   endtask

   task automatic test_sample_isolation();
      logic [3:0] expL;
      int blinkErr;
      waitCyc(320);
      applyStimulus(5000, 50);
      waitCyc(403);
      applyStimulus(7000, 99);
      waitCyc(415);
      expL = lightModel(5000, 415);
      total++; if (bcdValid !== 1'b1 || revBcd !== 20'h05000 || speedBcd !== 12'h050) begin bad++; $display("[TB] FAIL isolate_a: got %h/%h want 05000/050", revBcd, speedBcd); end
      total++; if (shiftLight !== expL) begin bad++; $display("[TB] FAIL isolate_light: got %b want %b", shiftLight, expL); end
      waitCyc(515);
      expL = lightModel(7000, 515);
      total++; if (bcdValid !== 1'b1 || revBcd !== 20'h07000 || speedBcd !== 12'h099) begin bad++; $display("[TB] FAIL isolate_b: got %h/%h want 07000/099", revBcd, speedBcd); end
      total++; if (shiftLight !== expL) begin bad++; $display("[TB] FAIL blink_start: got %b want %b", shiftLight, expL); end
      blinkErr = 0;
      for (int c = 516; c <= 765; c++) begin
         waitCyc(c);
         if (shiftLight !== blinkPhase(c)) blinkErr++;
      end
      total++; if (blinkErr !== 0) begin bad++; $display("[TB] FAIL blink_pattern: %0d wrong cycles want 0", blinkErr); end
   endtask

   task automatic test_shift_levels();
      int revs[6];
      int cap;
      logic [3:0] expL;
      revs = '{4900, 5000, 5500, 6000, 6499, 2000};
      for (int i = 0; i < 6; i++) begin
         cap = nextCapture();
         applyStimulus(revs[i], i * 37);
         waitCyc(cap + 15);
         expL = lightModel(revs[i], cap + 15);
         total++; if (revBcd !== toBcd5(revs[i]) || speedBcd !== toBcd3(i * 37)) begin bad++; $display("[TB] FAIL level_data[%0d]: got %h/%h want %h/%h", i, revBcd, speedBcd, toBcd5(revs[i]), toBcd3(i * 37)); end
         total++; if (shiftLight !== expL) begin bad++; $display("[TB] FAIL level_light[%0d]: rev=%0d got %b want %b", i, revs[i], shiftLight, expL); end
      end
   endtask

   task automatic test_reset_abort();
      int cap;
      int p0;
      logic [3:0] expL;
      cap = nextCapture();
      applyStimulus(3000, 42);
      waitCyc(cap + 6);
      p0  = pulses;
      rst = 1'b1;
      @(negedge clk);
      total++; if (revBcd !== 20'h0 || speedBcd !== 12'h0 || bcdValid !== 1'b0 || busy !== 1'b0 || shiftLight !== 4'h0) begin bad++; $display("[TB] FAIL abort_clear: rev=%h spd=%h v=%b b=%b l=%b want all 0", revBcd, speedBcd, bcdValid, busy, shiftLight); end
      repeat (2) @(negedge clk);
      blinkOn = 1'b0;
      applyStimulus(1234, 321);
      rst = 1'b0;
      waitCyc(114);
      total++; if (pulses !== p0) begin bad++; $display("[TB] FAIL abort_pulse: pulses=%0d want %0d", pulses, p0); end
      waitCyc(115);
      expL = lightModel(1234, 115);
      total++; if (bcdValid !== 1'b1 || revBcd !== 20'h01234 || speedBcd !== 12'h321 || shiftLight !== expL) begin bad++; $display("[TB] FAIL after_abort: v=%b got %h/%h l=%b want 1 01234/321 %b", bcdValid, revBcd, speedBcd, shiftLight, expL); end
   endtask

   task automatic test_random();
      int cap;
      int r;
      int s;
      logic [3:0] expL;
      for (int i = 0; i < 12; i++) begin
         r   = int'($urandom_range(0, 16383));
         s   = int'($urandom_range(0, 511));
         if (i % 4 == 3) r = int'($urandom_range(6300, 7500));
         cap = nextCapture();
         applyStimulus(r, s);
         waitCyc(cap + 3);
         applyStimulus(int'($urandom_range(0, 16383)), int'($urandom_range(0, 511)));
         waitCyc(cap + 15);
         expL = lightModel(r, cap + 15);
         total++; if (bcdValid !== 1'b1 || revBcd !== toBcd5(r) || speedBcd !== toBcd3(s)) begin bad++; $display("[TB] FAIL rand_data[%0d]: in %0d/%0d got %h/%h v=%b", i, r, s, revBcd, speedBcd, bcdValid); end
         total++; if (shiftLight !== expL) begin bad++; $display("[TB] FAIL rand_light[%0d]: rev=%0d got %b want %b", i, r, shiftLight, expL); end
      end
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      pulses       = 0;
      blinkOn      = 1'b0;
      blinkStart   = 0;
      rst          = 1'b1;
      engineRev    = '0;
      vehicleSpeed = '0;
      test_reset();
      test_first_valid();
      test_full_range();
      test_sample_isolation();
      test_shift_levels();
      test_reset_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
